// File: rtl/upower_decode_stage_if.sv
//------------------------------------------------------------------------------
// upower_decode_stage_if
//   Handshake and decoded-field bundle between fetch, the decode stage and the
//   64-bit ALU.
//
//   Fetch side : in_valid, in_ready, instr, flush
//   ALU side   : out_valid, out_ready, opcode, rs, rt, bo, bi, si, ds, xox,
//                xoxo, aa, xods, illegal
//
//   modport slave  : the decode stage itself
//   modport master : the environment driving fetch and consuming bundles
//------------------------------------------------------------------------------
interface upower_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  bo;
    logic [4:0]  bi;
    logic [15:0] si;
    logic [13:0] ds;
    logic [9:0]  xox;
    logic [8:0]  xoxo;
    logic        aa;
    logic [1:0]  xods;
    logic        illegal;

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, opcode, rs, rt, bo, bi, si, ds,
               xox, xoxo, aa, xods, illegal
    );

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, bo, bi, si, ds,
               xox, xoxo, aa, xods, illegal
    );
endinterface

// File: rtl/upower_decode_stage.sv
//------------------------------------------------------------------------------
// upower_decode_stage
//   Decodes 32-bit uPower instruction words into the ALU field inputs and
//   buffers the decoded bundles in a 2-entry skid FIFO so downstream stalls
//   never drop or duplicate an instruction.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        upower_decode_stage_if.slave (fetch handshake, flush,
//                ALU handshake and decoded fields)
//     issued_cnt count of bundles accepted downstream (wraps)
//
//   Parameters:
//     DEPTH      skid buffer entries (only 2 is supported)
//     CNT_W      width of issued_cnt
//------------------------------------------------------------------------------
module upower_decode_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    upower_decode_stage_if.slave  bus,
    output logic [CNT_W-1:0]      issued_cnt
);

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [15:0] si;
        logic [13:0] ds;
        logic [9:0]  xox;
        logic [8:0]  xoxo;
        logic        aa;
        logic [1:0]  xods;
        logic        illegal;
    } bundle_t;

    //--------------------------------------------------------------------------
    // Combinational decode of the presented word
    //--------------------------------------------------------------------------
    bundle_t w_dec;
    logic [5:0] w_op;
    logic [8:0] w_xo9;
    logic [9:0] w_xo10;

    assign w_op   = bus.instr[31:26];
    assign w_xo9  = bus.instr[9:1];
    assign w_xo10 = bus.instr[10:1];

    always_comb begin
        w_dec        = '0;
        w_dec.opcode = w_op;
        w_dec.rs     = bus.instr[25:21];
        w_dec.rt     = bus.instr[20:16];
        case (w_op)
            6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
            6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44: begin
                w_dec.si = bus.instr[15:0];
            end
            6'd18: begin
                w_dec.aa = bus.instr[1];
            end
            6'd19: begin
                w_dec.bo = bus.instr[25:21];
                w_dec.bi = bus.instr[20:16];
                w_dec.aa = bus.instr[1];
            end
            6'd31: begin
                // XO-form is tested first on the 9-bit field; none of the
                // X-form codes alias 266 or 40 in their low nine bits.
                if (w_xo9 == 9'd266 || w_xo9 == 9'd40) begin
                    w_dec.xoxo = w_xo9;
                end else if (w_xo10 == 10'd28  || w_xo10 == 10'd476 ||
                             w_xo10 == 10'd444 || w_xo10 == 10'd316 ||
                             w_xo10 == 10'd986) begin
                    w_dec.xox = w_xo10;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            6'd58, 6'd62: begin
                w_dec.ds   = bus.instr[15:2];
                w_dec.xods = bus.instr[1:0];
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // 2-entry skid FIFO (1-bit pointers wrap modulo 2)
    //--------------------------------------------------------------------------
    bundle_t          r_mem [DEPTH];
    bundle_t          r_last;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_issued;

    logic    w_in_ready;
    logic    w_out_valid;
    logic    w_push;
    logic    w_pop;
    bundle_t w_head;
    bundle_t w_view;

    // in_ready depends only on the registered count, never on out_ready.
    assign w_in_ready  = ({30'd0, r_count} < DEPTH);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_head      = r_mem[r_head];

    // When empty the head slot holds stale data, so the last delivered
    // bundle is replayed instead to keep the fields steady.
    assign w_view = w_out_valid ? w_head : r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_last   <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
            r_issued <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_dec;
            end
            if (w_pop) begin
                r_last   <= w_head;
                r_issued <= r_issued + 1'b1;
            end
            // A same-cycle dequeue still completes under flush; only the
            // occupancy and pointers are discarded.
            if (bus.flush) begin
                r_head  <= 1'b0;
                r_tail  <= 1'b0;
                r_count <= 2'd0;
            end else begin
                r_head  <= r_head ^ w_pop;
                r_tail  <= r_tail ^ w_push;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.opcode    = w_view.opcode;
    assign bus.rs        = w_view.rs;
    assign bus.rt        = w_view.rt;
    assign bus.bo        = w_view.bo;
    assign bus.bi        = w_view.bi;
    assign bus.si        = w_view.si;
    assign bus.ds        = w_view.ds;
    assign bus.xox       = w_view.xox;
    assign bus.xoxo      = w_view.xoxo;
    assign bus.aa        = w_view.aa;
    assign bus.xods      = w_view.xods;
    assign bus.illegal   = w_view.illegal;
    assign issued_cnt    = r_issued;

endmodule

// File: doc/upower_decode_stage.md
Name: upower_decode_stage

Overview:
- Instruction-decode pipeline stage directly upstream of the 64-bit ALU.
- Accepts 32-bit uPower instruction words from fetch over a valid/ready handshake.
- Splits each word into the ALU's field inputs (opcode, rs, rt, bo, bi, si, ds, xox, xoxo, aa, xods) and flags unsupported encodings.
- Holds results in a 2-entry skid buffer, so downstream stalls never drop or duplicate instructions. Supports a branch flush.

Parameters:
- DEPTH, 2, skid buffer entries (fixed at 2; other values unsupported)
- CNT_W, 32, width of the issued-instruction counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents instr
- in_ready  output  1  stage can accept instr this cycle
- instr  input  32  instruction word; bit 31 = PowerPC bit 0
- flush  input  1  discard all buffered instructions (branch taken)
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  ALU stage accepts bundle
- opcode  output  6  instr[31:26]
- rs, rt  output  5 each  instr[25:21], instr[20:16]
- bo, bi  output  5 each  instr[25:21], instr[20:16] for opcode 19, else 0
- si  output  16  instr[15:0] for D-form, else 0
- ds  output  14  instr[15:2] for opcode 58/62, else 0
- xox  output  10  instr[10:1] for opcode 31 X-form, else 0
- xoxo  output  9  instr[9:1] for opcode 31 XO-form, else 0
- aa  output  1  instr[1] for opcode 18/19, else 0
- xods  output  2  instr[1:0] for opcode 58/62, else 0
- illegal  output  1  bundle is an unsupported encoding
- issued_cnt  output  CNT_W  count of bundles accepted downstream

Behaviour:
- Decode is combinational on instr and is captured into the buffer on accept (in_valid & in_ready).
- D-form opcodes: 14, 15, 24, 26, 28, 32, 34, 36, 37, 38, 40, 42, 44.
- Opcode 31:
  - instr[9:1] is 266 or 40: XO-form. xoxo is set, xox = 0.
  - instr[10:1] is 28, 476, 444, 316 or 986: X-form. xox is set, xoxo = 0.
  - Anything else: illegal = 1, xox = xoxo = 0.
- Any opcode outside {14, 15, 18, 19, 24, 26, 28, 31, 32, 34, 36, 37, 38, 40, 42, 44, 58, 62}: illegal = 1. All field outputs except opcode, rs and rt are 0.
- Illegal bundles still flow through the handshake. The consumer decides what to do with them.
- Buffer:
  - 2-entry FIFO with head pointer, tail pointer and count.
  - in_ready = (count < 2), registered from count and not from out_ready.
  - out_valid = (count > 0).
  - Outputs show the head entry.
- Latency: an instruction accepted in cycle N appears at the outputs with out_valid = 1 in cycle N+1.
- Full throughput: with out_ready held high, one instruction per cycle streams through.
- Count update:
  - Accept and dequeue (out_valid & out_ready) in the same cycle: count unchanged, both pointers advance.
  - Count 2: in_ready = 0 and instr is ignored even if in_valid = 1.
  - Count 0: out_valid = 0. Output fields hold their last values; consumers must qualify them with out_valid.
- Pointers wrap modulo 2.
- flush:
  - count, head and tail clear to 0 on the next edge.
  - An accept in the same cycle is discarded.
  - A dequeue in the same cycle still completes and is counted.
- issued_cnt increments on each out_valid & out_ready and wraps at 2^CNT_W - 1 to 0.
- Reset (rst_n = 0, asynchronous, any time including mid-transfer):
  - count, pointers and issued_cnt clear to 0.
  - out_valid = 0, in_ready = 1 after release.
  - All field outputs and illegal read 0.
  - The first edge after release may accept.

Test Plan:
- Reset, then accept instr 0x7C642214 (op 31, rs 3, rt 4, xoxo 266) with out_ready = 1 -> next cycle out_valid = 1, opcode = 31, rs = 3, rt = 4, xoxo = 266, xox = 0, illegal = 0, issued_cnt = 1.
- Present op 36 word 0x910803E8 with out_ready = 0 -> si = 1000, ds = 0. Push a second word: in_ready is 0 after 2 accepts and a third presented word is not taken. Raise out_ready -> both emerge in order, then in_ready = 1.
- Stream 8 back-to-back words with out_ready = 1 -> 8 bundles on consecutive cycles, in order, issued_cnt = 8, pointers wrap without loss.
- op 58 word 0xE8A40005 -> ds = 1, xods = 1, si = 0. Word with opcode 1 -> illegal = 1, all other fields except opcode/rs/rt = 0.
- With 2 entries held, assert flush together with in_valid -> next cycle out_valid = 0 and count = 0. The same-cycle instr is not delivered.
- Assert rst_n = 0 asynchronously mid-stream between edges -> out_valid and issued_cnt drop to 0 immediately without waiting for a clock edge.
